// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/exec/commit sequencer owning the program-counter update path.
// Computes next PC for sequential, branch, jump and jump-register flow; counts retired instructions.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h00400000,
   parameter logic [31:0] EXC_VEC  = 32'h80000180
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic [31:0] rs_data,
   input  logic        stall,
   output logic [31:0] ir,
   output logic        IRWr,
   output logic        PCWr,
   output logic [31:0] pc_next,
   output logic        exc,
   output logic [2:0]  state,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      S_RST    = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_COMMIT = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      K_SEQ = 3'd0,
      K_BEQ = 3'd1,
      K_BNE = 3'd2,
      K_J   = 3'd3,
      K_JR  = 3'd4
   } kind_t;

   state_t      r_state, w_next;
   kind_t       r_kind, w_kind;
   logic        r_imem_req;
   logic        r_irwr;
   logic        r_exc;
   logic [31:0] r_ir;
   logic [31:0] r_pc_next;
   logic [31:0] r_retired;

   logic [31:0] w_seq;
   logic [31:0] w_br_off;
   logic [31:0] w_target;
   logic        w_misalign;

   assign w_seq    = pc_cur + 32'd4;
   assign w_br_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

   always_comb begin
      w_kind = K_SEQ;
      case (r_ir[31:26])
         6'b000100: w_kind = K_BEQ;
         6'b000101: w_kind = K_BNE;
         6'b000010,
         6'b000011: w_kind = K_J;
         6'b000000: if (r_ir[5:0] == 6'b001000) w_kind = K_JR;
         default:   w_kind = K_SEQ;
      endcase
   end

   // Target uses the kind latched in DECODE; operands are only meaningful in EXEC.
   always_comb begin
      w_target   = w_seq;
      w_misalign = 1'b0;
      case (r_kind)
         K_BEQ: w_target = zero  ? (w_seq + w_br_off) : w_seq;
         K_BNE: w_target = !zero ? (w_seq + w_br_off) : w_seq;
         K_J:   w_target = {w_seq[31:28], r_ir[25:0], 2'b00};
         K_JR: begin
            w_misalign = (rs_data[1:0] != 2'b00);
            w_target   = w_misalign ? EXC_VEC : rs_data;
         end
         default: w_target = w_seq;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RST:    w_next = S_FETCH;
         S_FETCH:  if (imem_ack) w_next = S_DECODE;
         S_DECODE: w_next = S_EXEC;
         S_EXEC:   w_next = S_COMMIT;
         S_COMMIT: if (!stall) w_next = S_FETCH;
         default:  w_next = S_FETCH;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state    <= S_RST;
         r_kind     <= K_SEQ;
         r_imem_req <= 1'b0;
         r_irwr     <= 1'b0;
         r_exc      <= 1'b0;
         r_ir       <= 32'd0;
         r_pc_next  <= RESET_PC;
         r_retired  <= 32'd0;
      end else begin
         r_state    <= w_next;
         // Request is registered so it rises on the first FETCH cycle.
         r_imem_req <= (w_next == S_FETCH);
         r_irwr     <= 1'b0;
         r_exc      <= 1'b0;
         case (r_state)
            S_FETCH: if (imem_ack) begin
               r_ir   <= instr;
               r_irwr <= 1'b1;
            end
            S_DECODE: r_kind <= w_kind;
            S_EXEC: begin
               r_pc_next <= w_target;
               r_exc     <= w_misalign;
            end
            S_COMMIT: if (!stall) r_retired <= r_retired + 32'd1;
            default: ;
         endcase
      end
   end

   assign imem_req = r_imem_req;
   assign IRWr     = r_irwr;
   assign exc      = r_exc;
   assign ir       = r_ir;
   assign pc_next  = r_pc_next;
   assign retired  = r_retired;
   assign state    = r_state;
   assign PCWr     = (r_state == S_COMMIT) && !stall;

endmodule
